// File: rtl/packet_demultiplexer_pkg.sv
// Shared definitions for the packet demultiplexer slice.
//   demux_state_t : input-side packet FSM states
//   DROP_CNT_W    : width of the dropped-packet counter
package demux_pkg;

  localparam int unsigned DROP_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ROUTE,
    DROP
  } demux_state_t;

endpackage

// File: rtl/packet_demultiplexer_if.sv
// Stream bundle for the packet demultiplexer: one valid/ready input stream
// (i_*) and N_STREAMS valid/ready output streams (o_*, packed per stream).
//   master : packet source and output consumers (drives i_*, o_ready)
//   slave  : the demultiplexer itself
interface packet_demultiplexer_if #(
  parameter int unsigned N_STREAMS  = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned SEL_WIDTH  = $clog2(N_STREAMS) + 1
);

  logic [DATA_WIDTH-1:0]                 i_data;
  logic                                  i_last;
  logic                                  i_valid;
  logic                                  i_ready;
  logic [SEL_WIDTH-1:0]                  i_select;
  logic [N_STREAMS-1:0][DATA_WIDTH-1:0]  o_data;
  logic [N_STREAMS-1:0]                  o_last;
  logic [N_STREAMS-1:0]                  o_valid;
  logic [N_STREAMS-1:0]                  o_ready;

  modport master (
    output i_data, i_last, i_valid, i_select, o_ready,
    input  i_ready, o_data, o_last, o_valid
  );

  modport slave (
    input  i_data, i_last, i_valid, i_select, o_ready,
    output i_ready, o_data, o_last, o_valid
  );

endinterface

// File: rtl/packet_demultiplexer_fifo.sv
// Per-output FIFO for the packet demultiplexer.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers only)
//   push/wdata : write side; push is ignored while full
//   full       : derived from registered pointers only, so a pop in the same
//                cycle never frees a slot for a push (no bypass)
//   pop/rdata  : read side; rdata is the head entry, valid while not empty
// Pointers carry one extra MSB so full and empty are distinguishable.
module demux_out_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: contents are only observable while valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign valid = !empty;

endmodule

// File: rtl/packet_demultiplexer.sv
// Packet demultiplexer: routes multi-beat packets from one valid/ready input
// stream to one of N_STREAMS buffered outputs.
//   clk, rst_n  : clock, asynchronous active-low reset
//   demux       : stream bundle (slave side) - i_data/i_last/i_valid/i_ready/
//                 i_select in, o_data/o_last/o_valid/o_ready per output
//   drop_count  : packets discarded for an out-of-range select (saturating)
// The destination is taken from i_select on a packet's first beat and held
// until its last beat is accepted, so packets are never interleaved.
module packet_demultiplexer
  import demux_pkg::*;
#(
  parameter int unsigned N_STREAMS    = 4,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          DROP_INVALID = 1'b1,
  parameter int unsigned SEL_WIDTH    = $clog2(N_STREAMS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  packet_demultiplexer_if.slave demux,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam logic [SEL_WIDTH-1:0] N_SEL = SEL_WIDTH'(N_STREAMS);

  demux_state_t                          state_q;
  logic [SEL_WIDTH-1:0]                  sel_q;
  logic [SEL_WIDTH-1:0]                  sel_eff;
  logic                                  sel_ok;
  logic                                  sel_full;
  logic                                  ready;
  logic                                  accept;
  logic [N_STREAMS-1:0]                  push;
  logic [N_STREAMS-1:0]                  full;
  logic [N_STREAMS-1:0]                  valid;
  logic [N_STREAMS-1:0]                  last;
  logic [N_STREAMS-1:0][DATA_WIDTH-1:0]  data;

  // Only the first beat of a packet looks at i_select.
  assign sel_eff = (state_q == ROUTE) ? sel_q : demux.i_select;
  assign sel_ok  = (sel_eff < N_SEL);
  assign accept  = demux.i_valid && ready;

  // Full flag of the effective destination; an out-of-range select matches
  // no stream and reads as not full (handled separately by sel_ok).
  always_comb begin
    sel_full = 1'b0;
    for (int unsigned i = 0; i < N_STREAMS; i++) begin
      if (sel_eff == SEL_WIDTH'(i)) sel_full = full[i];
    end
  end

  always_comb begin
    ready = 1'b0;
    case (state_q)
      IDLE:    ready = sel_ok ? !sel_full : DROP_INVALID;
      ROUTE:   ready = !sel_full;
      DROP:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_comb begin
    push = '0;
    for (int unsigned i = 0; i < N_STREAMS; i++) begin
      push[i] = accept && (state_q != DROP) && sel_ok && (sel_eff == SEL_WIDTH'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      drop_count <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (!sel_ok) begin
              // Counted on the first beat, so single-beat drops count too.
              if (drop_count != '1) drop_count <= drop_count + 1'b1;
              if (!demux.i_last) state_q <= DROP;
            end else if (!demux.i_last) begin
              state_q <= ROUTE;
              sel_q   <= demux.i_select;
            end
          end
        end
        ROUTE: if (accept && demux.i_last) state_q <= IDLE;
        DROP:  if (accept && demux.i_last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_STREAMS; g++) begin : g_out
    logic [DATA_WIDTH:0] rdata;

    demux_out_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[g]),
      .wdata ({demux.i_data, demux.i_last}),
      .full  (full[g]),
      .pop   (demux.o_ready[g]),
      .rdata (rdata),
      .valid (valid[g])
    );

    assign data[g] = rdata[DATA_WIDTH:1];
    assign last[g] = rdata[0];
  end

  assign demux.i_ready = ready;
  assign demux.o_valid = valid;
  assign demux.o_last  = last;
  assign demux.o_data  = data;

endmodule

// File: tb/tb_packet_demultiplexer.sv
// Scoreboard bench for packet_demultiplexer. dut_a drops invalid packets,
// dut_b stalls on them. Inputs change 1 time unit after posedge; the driver
// and the output monitor both sample on negedge.
module tb_packet_demultiplexer;
  import demux_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  packet_demultiplexer_if #(.N_STREAMS(N), .DATA_WIDTH(DW)) ifa ();
  packet_demultiplexer_if #(.N_STREAMS(N), .DATA_WIDTH(DW)) ifb ();
  logic [31:0] dca;
  logic [31:0] dcb;

  packet_demultiplexer #(
    .N_STREAMS(N), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .DROP_INVALID(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .demux(ifa.slave), .drop_count(dca)
  );

  packet_demultiplexer #(
    .N_STREAMS(N), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .DROP_INVALID(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .demux(ifb.slave), .drop_count(dcb)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
    bit            chk_lat;
  } ent_t;

  ent_t q [2][N][$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  logic [1:0][N-1:0]         mv, mr, ml;
  logic [1:0][N-1:0][DW-1:0] md;
  assign mv[0] = ifa.o_valid;  assign mv[1] = ifb.o_valid;
  assign mr[0] = ifa.o_ready;  assign mr[1] = ifb.o_ready;
  assign ml[0] = ifa.o_last;   assign ml[1] = ifb.o_last;
  assign md[0] = ifa.o_data;   assign md[1] = ifb.o_data;

  // Monitor: a beat presented with o_ready high is popped at the next edge.
  always @(negedge clk) begin
    ent_t e;
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < N; s++) begin
        if (mv[d][s] && mr[d][s]) begin
          checks++;
          if (q[d][s].size() == 0) begin
            failures++;
            $display("FAIL unexpected_out dut%0d out%0d: got data=%0h last=%0b, required no beat",
                     d, s, md[d][s], ml[d][s]);
          end else begin
            e = q[d][s].pop_front();
            if (md[d][s] !== e.data || ml[d][s] !== e.last) begin
              failures++;
              $display("FAIL out_beat dut%0d out%0d: got data=%0h last=%0b, required data=%0h last=%0b",
                       d, s, md[d][s], ml[d][s], e.data, e.last);
            end
            if (e.chk_lat) begin
              checks++;
              if (cyc != e.cyc + 1) begin
                failures++;
                $display("FAIL latency dut%0d out%0d data=%0h: got cycle %0d, required %0d",
                         d, s, e.data, cyc, e.cyc + 1);
              end
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [DW-1:0] data,
                       input logic last, input logic [SW-1:0] sel);
    if (d == 0) begin
      ifa.i_valid = v; ifa.i_data = data; ifa.i_last = last; ifa.i_select = sel;
    end else begin
      ifb.i_valid = v; ifb.i_data = data; ifb.i_last = last; ifb.i_select = sel;
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? ifa.i_ready : ifb.i_ready;
  endfunction

  // Offer one beat; on acceptance push its expectation (dest < 0: none).
  task automatic send_beat(input int d, input logic [DW-1:0] data, input logic last,
                           input logic [SW-1:0] sel, input int dest, input bit lat);
    bit ok = 1'b0;
    drive(d, 1'b1, data, last, sel);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rdy(d)) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout dut%0d data=%0h: got i_ready=0, required 1", d, data);
    end else if (dest >= 0) begin
      q[d][dest].push_back('{data: data, last: last, cyc: cyc, chk_lat: lat});
    end
    @(posedge clk); #1;
    drive(d, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    drive(0, 1'b0, '0, 1'b0, '0);
    drive(1, 1'b0, '0, 1'b0, '0);
    ifa.o_ready = '1;
    ifb.o_ready = '1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_o_valid_a", 64'(ifa.o_valid), 64'h0);
    chk("reset_drop_a", 64'(dca), 64'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready_a", 64'(ifa.i_ready), 64'h1);
    chk("idle_ready_b", 64'(ifb.i_ready), 64'h1);
    step();

    // 1: 3-beat packet to out 2, select toggled mid-packet
    send_beat(0, 64'hA1, 1'b0, 3'd2, 2, 1'b1);
    send_beat(0, 64'hA2, 1'b0, 3'd1, 2, 1'b1);
    send_beat(0, 64'hA3, 1'b1, 3'd3, 2, 1'b1);
    repeat (4) step();

    // 2: out 1 stalled, 6 single-beat packets
    ifa.o_ready[1] = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(0, 64'(i), 1'b1, 3'd1, 1, 1'b0);
    drive(0, 1'b1, 64'd4, 1'b1, 3'd1);
    repeat (3) begin
      @(negedge clk);
      chk("full_stall_ready", 64'(ifa.i_ready), 64'h0);
    end
    chk("full_stall_valid", 64'(ifa.o_valid[1]), 64'h1);
    step();
    ifa.o_ready[1] = 1'b1;
    send_beat(0, 64'd4, 1'b1, 3'd1, 1, 1'b0);
    send_beat(0, 64'd5, 1'b1, 3'd1, 1, 1'b0);
    repeat (8) step();

    // 3: packet to out 0 stuck mid-packet blocks a packet for out 3
    ifa.o_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(0, 64'h30 + 64'(i), 1'b0, 3'd0, 0, 1'b0);
    drive(0, 1'b1, 64'h34, 1'b0, 3'd3);
    repeat (4) begin
      @(negedge clk);
      chk("no_interleave_ready", 64'(ifa.i_ready), 64'h0);
      chk("no_interleave_out3", 64'(ifa.o_valid[3]), 64'h0);
    end
    step();
    ifa.o_ready[0] = 1'b1;
    send_beat(0, 64'h34, 1'b0, 3'd3, 0, 1'b0);
    send_beat(0, 64'h35, 1'b1, 3'd3, 0, 1'b0);
    send_beat(0, 64'h3F, 1'b1, 3'd3, 3, 1'b0);
    repeat (8) step();

    // 4: invalid select dropped on dut_a
    drive(0, 1'b1, 64'h51, 1'b0, 3'd5);
    @(negedge clk);
    chk("drop_ready_first", 64'(ifa.i_ready), 64'h1);
    step();
    drive(0, 1'b1, 64'h52, 1'b1, 3'd0);
    @(negedge clk);
    chk("drop_ready_last", 64'(ifa.i_ready), 64'h1);
    step();
    drive(0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    chk("drop_count_a", 64'(dca), 64'h1);
    step();
    send_beat(0, 64'h40, 1'b1, 3'd0, 0, 1'b0);
    repeat (4) step();

    // 5: invalid select stalls dut_b
    drive(1, 1'b1, 64'h50, 1'b1, 3'd4);
    repeat (10) begin
      @(negedge clk);
      chk("stall_invalid_ready", 64'(ifb.i_ready), 64'h0);
    end
    chk("stall_drop_count_b", 64'(dcb), 64'h0);
    step();
    send_beat(1, 64'h50, 1'b1, 3'd1, 1, 1'b0);
    repeat (4) step();
    chk("drop_count_b_after", 64'(dcb), 64'h0);

    // 6: reset mid-packet with out 2 partly full
    ifa.o_ready[2] = 1'b0;
    send_beat(0, 64'h60, 1'b0, 3'd2, 2, 1'b0);
    send_beat(0, 64'h61, 1'b0, 3'd2, 2, 1'b0);
    @(negedge clk);
    chk("pre_reset_valid2", 64'(ifa.o_valid[2]), 64'h1);
    step();
    rst_n = 1'b0;
    for (int s = 0; s < N; s++) begin
      q[0][s].delete();
      q[1][s].delete();
    end
    @(negedge clk);
    chk("mid_reset_o_valid", 64'(ifa.o_valid), 64'h0);
    chk("mid_reset_drop", 64'(dca), 64'h0);
    step();
    ifa.o_ready[2] = 1'b1;
    rst_n = 1'b1;
    step();
    send_beat(0, 64'h70, 1'b0, 3'd3, 3, 1'b1);
    send_beat(0, 64'h71, 1'b1, 3'd0, 3, 1'b1);
    repeat (10) step();

    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < N; s++) chk("queue_drained", 64'(q[d][s].size()), 64'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
